// File: rtl/io_dly_serial_ctrl_if.sv
// Command/readback port of the IO delay serial controller.
interface io_dly_serial_ctrl_if #(
  parameter int unsigned CHAIN_LEN = 12
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_load;
  logic                 cmd_sel;
  logic [CHAIN_LEN-1:0] cmd_data;
  logic [CHAIN_LEN-1:0] rd_data;
  logic                 done;

  modport master (
    output cmd_valid, cmd_load, cmd_sel, cmd_data,
    input  cmd_ready, rd_data, done
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_sel, cmd_data,
    output cmd_ready, rd_data, done
  );
endinterface

// File: rtl/io_dly_serial_ctrl.sv
// Shifts a parallel delay word MSB first into the IO delay cell chain on
// SCLK/SDI, captures the old chain contents from SDO, and steers C_R_SEL.
module io_dly_serial_ctrl #(
  parameter int unsigned CHAIN_LEN = 12,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  io_dly_serial_ctrl_if.slave  cmd,
  output logic                 SCLK,
  output logic                 SDI,
  input  logic                 SDO,
  output logic                 C_R_SEL
);

  localparam int unsigned BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t               state_q, state_nxt;
  logic                 ready_q, ready_nxt;
  logic                 sclk_q, sclk_nxt;
  logic                 sdi_q, sdi_nxt;
  logic                 crsel_q, crsel_nxt;
  logic                 done_q, done_nxt;
  logic [CHAIN_LEN-1:0] rd_q, rd_nxt;
  logic [CHAIN_LEN-1:0] sr_q, sr_nxt;
  logic [BIT_W-1:0]     bit_q, bit_nxt;
  logic [DIV_W-1:0]     div_q, div_nxt;
  logic                 sel_q, sel_nxt;
  logic                 load_q, load_nxt;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      sclk_q  <= 1'b0;
      sdi_q   <= 1'b0;
      crsel_q <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= '0;
      sr_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      sel_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ready_q <= ready_nxt;
      sclk_q  <= sclk_nxt;
      sdi_q   <= sdi_nxt;
      crsel_q <= crsel_nxt;
      done_q  <= done_nxt;
      rd_q    <= rd_nxt;
      sr_q    <= sr_nxt;
      bit_q   <= bit_nxt;
      div_q   <= div_nxt;
      sel_q   <= sel_nxt;
      load_q  <= load_nxt;
    end
  end

  // Next-state and next-output logic; SDI only moves at acceptance or on SCLK fall.
  always_comb begin
    state_nxt = state_q;
    ready_nxt = 1'b0;
    sclk_nxt  = sclk_q;
    sdi_nxt   = sdi_q;
    crsel_nxt = crsel_q;
    done_nxt  = 1'b0;
    rd_nxt    = rd_q;
    sr_nxt    = sr_q;
    bit_nxt   = bit_q;
    div_nxt   = div_q;
    sel_nxt   = sel_q;
    load_nxt  = load_q;

    case (state_q)
      IDLE: begin
        ready_nxt = 1'b1;
        if (cmd.cmd_valid && ready_q) begin
          ready_nxt = 1'b0;
          sel_nxt   = cmd.cmd_sel;
          load_nxt  = cmd.cmd_load;
          if (cmd.cmd_load) begin
            sr_nxt    = cmd.cmd_data;
            sdi_nxt   = cmd.cmd_data[CHAIN_LEN-1];
            crsel_nxt = 1'b0;
            bit_nxt   = '0;
            div_nxt   = '0;
            state_nxt = SHIFT_LO;
          end else begin
            state_nxt = DONE;
          end
        end
      end

      SHIFT_LO: begin
        if (div_q == DIV_LAST) begin
          sclk_nxt  = 1'b1;
          sr_nxt    = {sr_q[CHAIN_LEN-2:0], SDO};
          div_nxt   = '0;
          state_nxt = SHIFT_HI;
        end else begin
          div_nxt = div_q + DIV_W'(1);
        end
      end

      SHIFT_HI: begin
        if (div_q == DIV_LAST) begin
          sclk_nxt = 1'b0;
          div_nxt  = '0;
          if (bit_q == BIT_LAST) begin
            state_nxt = DONE;
          end else begin
            bit_nxt   = bit_q + BIT_W'(1);
            sdi_nxt   = sr_q[CHAIN_LEN-1];
            state_nxt = SHIFT_LO;
          end
        end else begin
          div_nxt = div_q + DIV_W'(1);
        end
      end

      DONE: begin
        done_nxt  = 1'b1;
        crsel_nxt = sel_q;
        if (load_q) begin
          rd_nxt = sr_q;
        end
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign cmd.cmd_ready = ready_q;
  assign cmd.done      = done_q;
  assign cmd.rd_data   = rd_q;
  assign SCLK          = sclk_q;
  assign SDI           = sdi_q;
  assign C_R_SEL       = crsel_q;

endmodule

// File: tb/tb_io_dly_serial_ctrl.sv
// Directed bench: a CLK_DIV=2 controller and a CLK_DIV=1 controller, each
// driving a 12-bit serial chain model.
module tb_io_dly_serial_ctrl;
  localparam int unsigned L = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_dly_serial_ctrl_if #(.CHAIN_LEN(L)) if_a ();
  io_dly_serial_ctrl_if #(.CHAIN_LEN(L)) if_b ();

  logic sclk_a, sdi_a, crsel_a;
  logic sclk_b, sdi_b, crsel_b;
  logic [L-1:0] chain_a = '0;
  logic [L-1:0] chain_b = '0;
  logic sclk_a_d = 1'b0;
  logic sclk_b_d = 1'b0;
  logic pre_a = 1'b0;
  logic pre_b = 1'b0;
  logic [L-1:0] pre_val = '0;
  wire sdo_a = chain_a[L-1];
  wire sdo_b = chain_b[L-1];

  int checks = 0;
  int errors = 0;

  io_dly_serial_ctrl #(.CHAIN_LEN(L), .CLK_DIV(2)) dut_a (
    .CLK(clk), .RST(rst), .cmd(if_a.slave),
    .SCLK(sclk_a), .SDI(sdi_a), .SDO(sdo_a), .C_R_SEL(crsel_a)
  );

  io_dly_serial_ctrl #(.CHAIN_LEN(L), .CLK_DIV(1)) dut_b (
    .CLK(clk), .RST(rst), .cmd(if_b.slave),
    .SCLK(sclk_b), .SDI(sdi_b), .SDO(sdo_b), .C_R_SEL(crsel_b)
  );

  // Chain models: shift SDI in on each observed SCLK rise, MSB drives SDO.
  always @(posedge clk) begin
    sclk_a_d <= sclk_a;
    if (pre_a) chain_a <= pre_val;
    else if (sclk_a && !sclk_a_d) chain_a <= {chain_a[L-2:0], sdi_a};
  end

  always @(posedge clk) begin
    sclk_b_d <= sclk_b;
    if (pre_b) chain_b <= pre_val;
    else if (sclk_b && !sclk_b_d) chain_b <= {chain_b[L-2:0], sdi_b};
  end

  logic use_b = 1'b0;
  wire         m_sclk  = use_b ? sclk_b : sclk_a;
  wire         m_sdi   = use_b ? sdi_b : sdi_a;
  wire         m_crsel = use_b ? crsel_b : crsel_a;
  wire         m_done  = use_b ? if_b.done : if_a.done;
  wire         m_ready = use_b ? if_b.cmd_ready : if_a.cmd_ready;
  wire [L-1:0] m_rd    = use_b ? if_b.rd_data : if_a.rd_data;
  wire [L-1:0] m_chain = use_b ? chain_b : chain_a;

  task automatic drive(input logic v, input logic ld, input logic sl, input logic [L-1:0] d);
    if (use_b) begin
      if_b.cmd_valid = v; if_b.cmd_load = ld; if_b.cmd_sel = sl; if_b.cmd_data = d;
    end else begin
      if_a.cmd_valid = v; if_a.cmd_load = ld; if_a.cmd_sel = sl; if_a.cmd_data = d;
    end
  endtask

  task automatic preload(input logic [L-1:0] v);
    pre_val = v;
    if (use_b) pre_b = 1'b1; else pre_a = 1'b1;
    @(posedge clk); #1;
    pre_a = 1'b0;
    pre_b = 1'b0;
  endtask

  // Returns once the edge that accepted the command has passed (1ns after it).
  task automatic wait_accept(input string nm, output bit ok);
    logic rdy;
    ok = 1'b0;
    for (int g = 0; g < 100; g++) begin
      rdy = m_ready;
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s accept: got no acceptance want acceptance within 100 cycles", nm);
    end
  endtask

  task automatic run_load(input string nm, input int div, input logic [L-1:0] data,
                          input logic sel, input logic [L-1:0] pre);
    bit ok;
    int rises, falls, last;
    logic prev;
    preload(pre);
    drive(1'b1, 1'b1, sel, data);
    wait_accept(nm, ok);
    drive(1'b0, 1'b0, 1'b0, '0);
    if (!ok) return;
    last  = 2 * div * int'(L);
    rises = 0;
    falls = 0;
    prev  = 1'b0;
    for (int n = 1; n <= last + 1; n++) begin
      @(posedge clk); #1;
      if (m_sclk && !prev) begin
        checks++;
        if (n != div * (2 * rises + 1)) begin
          errors++;
          $display("FAIL %s rise%0d time: got T+%0d want T+%0d", nm, rises, n, div * (2 * rises + 1));
        end
        if (rises < int'(L)) begin
          checks++;
          if (m_sdi !== data[int'(L) - 1 - rises]) begin
            errors++;
            $display("FAIL %s sdi bit%0d: got %b want %b", nm, rises, m_sdi, data[int'(L) - 1 - rises]);
          end
        end
        rises++;
      end
      if (!m_sclk && prev) begin
        checks++;
        if (n != 2 * div * (falls + 1)) begin
          errors++;
          $display("FAIL %s fall%0d time: got T+%0d want T+%0d", nm, falls, n, 2 * div * (falls + 1));
        end
        falls++;
      end
      if (n <= last) begin
        checks++;
        if (m_done !== 1'b0 || m_crsel !== 1'b0) begin
          errors++;
          $display("FAIL %s shift T+%0d: got done=%b csel=%b want done=0 csel=0", nm, n, m_done, m_crsel);
        end
      end
      prev = m_sclk;
    end
    checks++;
    if (m_done !== 1'b1 || m_crsel !== sel || m_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s done T+%0d: got done=%b csel=%b rdy=%b want 1 %b 0", nm, last + 1, m_done, m_crsel, m_ready, sel);
    end
    checks++;
    if (m_rd !== pre) begin
      errors++;
      $display("FAIL %s rd_data: got %h want %h", nm, m_rd, pre);
    end
    checks++;
    if (m_chain !== data) begin
      errors++;
      $display("FAIL %s chain: got %h want %h", nm, m_chain, data);
    end
    checks++;
    if (rises != int'(L) || falls != int'(L)) begin
      errors++;
      $display("FAIL %s pulse count: got %0d/%0d want %0d/%0d", nm, rises, falls, L, L);
    end
    @(posedge clk); #1;
    checks++;
    if (m_done !== 1'b0 || m_ready !== 1'b1 || m_sclk !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: got done=%b rdy=%b sclk=%b want 0 1 0", nm, m_done, m_ready, m_sclk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (if_a.cmd_ready !== 1'b1 || sclk_a !== 1'b0 || sdi_a !== 1'b0 || crsel_a !== 1'b0 ||
        if_a.done !== 1'b0 || if_a.rd_data !== '0) begin
      errors++;
      $display("FAIL reset_a: got rdy=%b sclk=%b sdi=%b csel=%b done=%b rd=%h want 1 0 0 0 0 000",
               if_a.cmd_ready, sclk_a, sdi_a, crsel_a, if_a.done, if_a.rd_data);
    end
    checks++;
    if (if_b.cmd_ready !== 1'b1 || sclk_b !== 1'b0 || crsel_b !== 1'b0 || if_b.rd_data !== '0) begin
      errors++;
      $display("FAIL reset_b: got rdy=%b sclk=%b csel=%b rd=%h want 1 0 0 000",
               if_b.cmd_ready, sclk_b, crsel_b, if_b.rd_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (if_a.cmd_ready !== 1'b1 || sclk_a !== 1'b0 || if_a.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got rdy=%b sclk=%b done=%b want 1 0 0", if_a.cmd_ready, sclk_a, if_a.done);
    end
  endtask

  task automatic test_load();
    use_b = 1'b0;
    run_load("load_a5c", 2, 12'hA5C, 1'b1, 12'h3F0);
  endtask

  task automatic test_select_only();
    bit ok;
    use_b = 1'b0;
    checks++;
    if (crsel_a !== 1'b1) begin
      errors++;
      $display("FAIL sel_pre: got csel=%b want 1", crsel_a);
    end
    drive(1'b1, 1'b0, 1'b0, 12'hFFF);
    wait_accept("sel_only", ok);
    drive(1'b0, 1'b0, 1'b0, '0);
    if (!ok) return;
    @(posedge clk); #1;
    checks++;
    if (if_a.done !== 1'b1 || crsel_a !== 1'b0 || sclk_a !== 1'b0 || if_a.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL sel_only T+1: got done=%b csel=%b sclk=%b rdy=%b want 1 0 0 0",
               if_a.done, crsel_a, sclk_a, if_a.cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (if_a.done !== 1'b0 || if_a.cmd_ready !== 1'b1 || sclk_a !== 1'b0) begin
      errors++;
      $display("FAIL sel_only T+2: got done=%b rdy=%b sclk=%b want 0 1 0", if_a.done, if_a.cmd_ready, sclk_a);
    end
    checks++;
    if (if_a.rd_data !== 12'h3F0 || chain_a !== 12'hA5C) begin
      errors++;
      $display("FAIL sel_only data: got rd=%h chain=%h want 3f0 a5c", if_a.rd_data, chain_a);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    use_b = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 12'h123);
    wait_accept("b2b", ok);
    drive(1'b1, 1'b1, 1'b0, 12'hC3A);
    if (!ok) return;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (n == 49) begin
        checks++;
        if (if_a.done !== 1'b1 || if_a.cmd_ready !== 1'b0 || crsel_a !== 1'b1 || if_a.rd_data !== 12'hA5C) begin
          errors++;
          $display("FAIL b2b first done: got done=%b rdy=%b csel=%b rd=%h want 1 0 1 a5c",
                   if_a.done, if_a.cmd_ready, crsel_a, if_a.rd_data);
        end
      end
      if (n == 50) begin
        checks++;
        if (if_a.cmd_ready !== 1'b1 || if_a.done !== 1'b0) begin
          errors++;
          $display("FAIL b2b ready: got rdy=%b done=%b want 1 0", if_a.cmd_ready, if_a.done);
        end
      end
      if (n == 51) begin
        checks++;
        if (if_a.cmd_ready !== 1'b0 || crsel_a !== 1'b0 || sdi_a !== 1'b1) begin
          errors++;
          $display("FAIL b2b second accept: got rdy=%b csel=%b sdi=%b want 0 0 1", if_a.cmd_ready, crsel_a, sdi_a);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
      end
      if (n >= 48 && n <= 52) begin
        checks++;
        if (sclk_a !== 1'b0) begin
          errors++;
          $display("FAIL b2b gap T+%0d: got sclk=%b want 0", n, sclk_a);
        end
      end
      if (n == 53) begin
        checks++;
        if (sclk_a !== 1'b1) begin
          errors++;
          $display("FAIL b2b second rise: got sclk=%b want 1", sclk_a);
        end
      end
      if (n == 99) begin
        checks++;
        if (if_a.done !== 1'b0) begin
          errors++;
          $display("FAIL b2b early done: got done=%b want 0", if_a.done);
        end
      end
    end
    checks++;
    if (if_a.done !== 1'b1 || crsel_a !== 1'b0 || if_a.rd_data !== 12'h123 || chain_a !== 12'hC3A) begin
      errors++;
      $display("FAIL b2b second done: got done=%b csel=%b rd=%h chain=%h want 1 0 123 c3a",
               if_a.done, crsel_a, if_a.rd_data, chain_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    use_b = 1'b0;
    preload(12'h000);
    drive(1'b1, 1'b1, 1'b1, 12'hFFF);
    wait_accept("rst_mid", ok);
    drive(1'b0, 1'b0, 1'b0, '0);
    if (!ok) return;
    repeat (22) @(posedge clk);
    #1;
    checks++;
    if (sclk_a !== 1'b1 || if_a.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid bit5 high: got sclk=%b rdy=%b want 1 0", sclk_a, if_a.cmd_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (sclk_a !== 1'b0 || crsel_a !== 1'b0 || if_a.cmd_ready !== 1'b1 || if_a.done !== 1'b0 ||
        sdi_a !== 1'b0 || if_a.rd_data !== '0) begin
      errors++;
      $display("FAIL rst_mid after: got sclk=%b csel=%b rdy=%b done=%b sdi=%b rd=%h want 0 0 1 0 0 000",
               sclk_a, crsel_a, if_a.cmd_ready, if_a.done, sdi_a, if_a.rd_data);
    end
    run_load("rst_mid_follow", 2, 12'h0F3, 1'b1, 12'h9C6);
  endtask

  task automatic test_div1();
    use_b = 1'b1;
    run_load("div1_fff", 1, 12'hFFF, 1'b1, 12'h5A5);
    use_b = 1'b0;
  endtask

  initial begin
    use_b = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    use_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    test_reset();
    test_load();
    test_select_only();
    test_back_to_back();
    test_reset_mid_shift();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
